sdram_cell_writer: RTL and testbench

Avalon-MM master that writes particle-cell updates into the SDRAM framebuffer that the VGA renderer reads. Accepts single-cell write requests (x, y, cell type) through a valid/ready port, queues them, and performs a read-modify-write of the 16-bit SDRAM word that packs the target cell. Sits between the simulation/brush logic and the SDRAM controller, on a master port separate from the renderer's.

---
 rtl/fallingsand_pkg.sv | 49 ++++
 rtl/cell_req_fifo.sv | 58 +++++
 rtl/sdram_cell_writer.sv | 110 +++++++++++
 tb/tb_sdram_cell_writer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fallingsand_pkg.sv
// Shared falling-sand definitions: cell encoding, grid geometry and
// framebuffer word packing helpers used by the cell writer and the renderer.
package fallingsand_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SAND  = 2'd1,
    WATER = 2'd2,
    WALL  = 2'd3
  } cell_t;

  localparam int unsigned COLS           = 640;
  localparam int unsigned ROWS           = 480;
  localparam int unsigned CELLS_PER_WORD = 8;
  localparam int unsigned WORDS_PER_ROW  = COLS / CELLS_PER_WORD;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    cell_t       t;
  } cell_req_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } writer_state_t;

  // Constant multiplier folds to one shifted adder per set bit (80 = 64 + 16).
  function automatic logic [23:0] row_offset(input logic [9:0] y,
                                             input int unsigned words_per_row);
    logic [23:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (words_per_row[i]) acc = acc + (24'(y) << i);
    end
    return acc;
  endfunction

  function automatic logic [15:0] insert_cell(input logic [15:0] word,
                                              input logic [2:0]  k,
                                              input cell_t       t);
    logic [15:0] mask;
    mask = 16'h0003 << {k, 1'b0};
    return (word & ~mask) | (16'(t) << {k, 1'b0});
  endfunction

endpackage

// File: rtl/cell_req_fifo.sv
// Small synchronous request queue for cell writes; full/empty are registered
// so the upstream ready never depends on same-cycle pops.
module cell_req_fifo
  import fallingsand_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  cell_req_t push_data,
  input  logic      pop,
  output cell_req_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cell_req_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    do_push    = push && !full;
    do_pop     = pop && !empty;
    count_next = count;
    if (do_push && !do_pop) count_next = count + (AW+1)'(1);
    else if (!do_push && do_pop) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sdram_cell_writer.sv
// Avalon-MM master that applies queued single-cell updates to the packed
// framebuffer by read-modify-write of the 16-bit word holding the cell.
module sdram_cell_writer #(
  parameter int unsigned COLS       = 640,
  parameter int unsigned ROWS       = 480,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] screen_ptr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_x,
  input  logic [9:0]  req_y,
  input  logic [1:0]  req_t,
  output logic        busy,
  output logic        dropped,
  output logic [23:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata
);

  import fallingsand_pkg::*;

  cell_req_t     push_data;
  cell_req_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  writer_state_t state;
  writer_state_t state_next;
  logic [2:0]    k_q;
  cell_t         t_q;
  logic          unused_ptr_bits;

  assign unused_ptr_bits = ^screen_ptr[31:24];

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign in_range  = (32'(req_x) < COLS) && (32'(req_y) < ROWS);
  assign push      = accept && in_range;
  assign push_data = '{x: req_x, y: req_y, t: cell_t'(req_t)};
  assign busy      = !fifo_empty || (state != IDLE);

  cell_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = RD_REQ;
        end
      end
      RD_REQ:  if (!mem_waitrequest) state_next = RD_WAIT;
      RD_WAIT: if (mem_readdatavalid) state_next = WR_REQ;
      WR_REQ:  if (!mem_waitrequest) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Commands are registered from the next state so they line up with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      k_q           <= '0;
      t_q           <= EMPTY;
      dropped       <= 1'b0;
    end else begin
      state     <= state_next;
      mem_read  <= (state_next == RD_REQ);
      mem_write <= (state_next == WR_REQ);
      dropped   <= accept && !in_range;
      if (pop) begin
        mem_address <= screen_ptr[23:0]
                     + row_offset(head.y, COLS / CELLS_PER_WORD)
                     + 24'(head.x[10:3]);
        k_q         <= head.x[2:0];
        t_q         <= head.t;
      end
      if ((state == RD_WAIT) && mem_readdatavalid)
        mem_writedata <= insert_cell(mem_readdata, k_q, t_q);
    end
  end

endmodule

// File: tb/tb_sdram_cell_writer.sv
// Randomised bench for sdram_cell_writer with an Avalon slave model and a
// transaction-level reference model of the queued read-modify-write updates.
module tb_sdram_cell_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] screen_ptr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_x = '0;
  logic [9:0]  req_y = '0;
  logic [1:0]  req_t = '0;
  logic        busy;
  logic        dropped;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata = '0;

  sdram_cell_writer #(
    .COLS      (640),
    .ROWS      (480),
    .FIFO_DEPTH(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .screen_ptr       (screen_ptr),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_x            (req_x),
    .req_y            (req_y),
    .req_t            (req_t),
    .busy             (busy),
    .dropped          (dropped),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_readdata     (mem_readdata)
  );

  always #10 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  typedef struct { int x; int y; int t; } req_s;
  req_s        q[$];
  bit          head_read = 0;
  bit          head_rdv  = 0;
  bit          drop_exp  = 0;
  logic [15:0] mem_a [int];
  int          rd_due[$];
  logic [15:0] rd_data[$];
  int          cyc = 0;
  int          wait_mode = 0;   // 0 never stall, 1 random stall, 2 always stall
  int          lat = 2;
  bit          prev_stall = 0;
  logic [23:0] prev_addr;
  logic        prev_rd, prev_wr;
  logic [15:0] prev_wd;
  logic [23:0] last_rd_addr = '0;
  logic [23:0] last_wr_addr = '0;
  logic [15:0] last_wr_data = '0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          drop_seen = 0;

  function automatic logic [15:0] mem_rd(input int a);
    if (mem_a.exists(a)) return mem_a[a];
    return 16'((a * 40503) ^ 23130);
  endfunction

  function automatic int exp_addr(input int x, input int y);
    longint s;
    s = longint'(screen_ptr[23:0]) + longint'(y) * 80 + longint'(x / 8);
    return int'(s % 64'd16777216);
  endfunction

  function automatic logic [15:0] put_cell(input logic [15:0] w, input int k, input int t);
    logic [15:0] r;
    r = w;
    r[2*k]   = t[0];
    r[2*k+1] = t[1];
    return r;
  endfunction

  // Slave model and per-cycle compare, both evaluated mid-cycle.
  always @(negedge clock) begin
    int a;
    logic [15:0] e;
    cyc++;
    if (reset) begin
      q.delete();
      head_read = 0;
      head_rdv = 0;
      drop_exp = 0;
      prev_stall = 0;
      mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b0;
    end else begin
      mem_waitrequest = (wait_mode == 2) ? 1'b1 :
                        (wait_mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
        mem_readdatavalid = 1'b1;
        mem_readdata = rd_data[0];
        void'(rd_due.pop_front());
        void'(rd_data.pop_front());
      end else begin
        mem_readdatavalid = 1'b0;
        mem_readdata = 16'($urandom);
      end

      check("busy", 32'(busy), 32'(q.size() != 0));
      check("req_ready", 32'(req_ready),
            32'((q.size() - ((head_read || mem_read) ? 1 : 0)) < 4));
      check("dropped", 32'(dropped), 32'(drop_exp));
      if (dropped) drop_seen++;
      check("rd_wr_exclusive", 32'(mem_read && mem_write), 0);
      check("spurious_read", 32'(mem_read && (q.size() == 0 || head_read)), 0);
      check("spurious_write", 32'(mem_write && !head_rdv), 0);
      if (prev_stall) begin
        check("hold_address", 32'(mem_address), 32'(prev_addr));
        check("hold_cmd", 32'({mem_read, mem_write}), 32'({prev_rd, prev_wr}));
        check("hold_writedata", 32'(mem_writedata), 32'(prev_wd));
      end

      if (mem_read && !mem_waitrequest && q.size() > 0 && !head_read) begin
        a = exp_addr(q[0].x, q[0].y);
        check("read_address", 32'(mem_address), 32'(a));
        rd_due.push_back(cyc + lat);
        rd_data.push_back(mem_rd(a));
        head_read = 1;
        last_rd_addr = mem_address;
        rd_count++;
      end
      if (mem_write && !mem_waitrequest && q.size() > 0 && head_rdv) begin
        a = exp_addr(q[0].x, q[0].y);
        e = put_cell(mem_rd(a), q[0].x % 8, q[0].t);
        check("write_address", 32'(mem_address), 32'(a));
        check("write_data", 32'(mem_writedata), 32'(e));
        mem_a[a] = e;
        last_wr_addr = mem_address;
        last_wr_data = mem_writedata;
        wr_count++;
        void'(q.pop_front());
        head_read = 0;
        head_rdv = 0;
      end
      if (mem_readdatavalid && head_read) head_rdv = 1;

      prev_stall = (mem_read || mem_write) && mem_waitrequest;
      prev_addr = mem_address;
      prev_rd = mem_read;
      prev_wr = mem_write;
      prev_wd = mem_writedata;

      drop_exp = 0;
      if (req_valid && req_ready) begin
        if (req_x < 11'd640 && req_y < 10'd480)
          q.push_back('{x: int'(req_x), y: int'(req_y), t: int'(req_t)});
        else
          drop_exp = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int x, input int y, input int t);
    int n;
    req_x = 11'(x);
    req_y = 10'(y);
    req_t = 2'(t);
    req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (req_ready) break;
      n++;
      if (n > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: req_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (!busy && rd_due.size() == 0) break;
      n++;
      if (n > 600) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, n);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_dropped"}, 32'(dropped), 0);
    check({tag, "_mem_read"}, 32'(mem_read), 0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_mem_address"}, 32'(mem_address), 0);
    check({tag, "_mem_writedata"}, 32'(mem_writedata), 0);
  endtask

  initial begin
    int w0, d0, r0, n;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Hand-computed anchor: 0x1000 + 2*80 + 13/8 = 0x10A1, field 5 <- 2 on 0xFFFF.
    screen_ptr = 32'h0000_1000;
    mem_a[32'h10A1] = 16'hFFFF;
    lat = 2;
    send(13, 2, 2);
    wait_idle();
    check("anchor_rd_addr", 32'(last_rd_addr), 32'h10A1);
    check("anchor_wr_addr", 32'(last_wr_addr), 32'h10A1);
    check("anchor_wr_data", 32'(last_wr_data), 32'hFBFF);

    screen_ptr = 32'h0;
    mem_a[0] = 16'h0000;
    mem_a[80] = 16'h0000;
    send(0, 0, 3);
    wait_idle();
    check("wall_x0_data", 32'(last_wr_data), 32'h0003);
    send(7, 1, 1);
    wait_idle();
    check("sand_x7_addr", 32'(last_wr_addr), 32'h50);
    check("sand_x7_data", 32'(last_wr_data), 32'h4000);

    // Out-of-range requests: pulse only, no bus traffic.
    w0 = wr_count; r0 = rd_count; d0 = drop_seen;
    send(640, 0, 1);
    send(5, 480, 2);
    repeat (4) @(posedge clock);
    #1;
    check("drop_pulses", 32'(drop_seen - d0), 2);
    check("drop_no_read", 32'(rd_count - r0), 0);
    check("drop_no_write", 32'(wr_count - w0), 0);

    // Backpressure: bus stalled, queue fills, then drains in order.
    w0 = wr_count;
    wait_mode = 2;
    fork
      begin
        for (int i = 0; i < 6; i++) send(8 * i + i, 10 + i, i % 4);
      end
      begin
        repeat (15) @(negedge clock);
        check("bp_ready_low", 32'(req_ready), 0);
        check("bp_read_held", 32'(mem_read), 1);
        check("bp_no_write", 32'(wr_count - w0), 0);
        wait_mode = 1;
      end
    join
    wait_idle();
    check("bp_all_written", 32'(wr_count - w0), 6);

    // Randomised phases, including a base near the 24-bit wrap.
    for (int ph = 0; ph < 5; ph++) begin
      screen_ptr = (ph == 4) ? 32'hABFF_FFF0 : $urandom;
      lat = $urandom_range(1, 4);
      wait_mode = (ph == 0) ? 0 : 1;
      for (int i = 0; i < 40; i++) begin
        send($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
      end
      wait_idle();
    end

    // Reset while the read is outstanding; the late read data must be ignored.
    wait_mode = 0;
    lat = 6;
    w0 = wr_count;
    screen_ptr = 32'h0000_2000;
    send(3, 3, 3);
    n = 0;
    forever begin
      @(negedge clock);
      if (head_read && !mem_read && !mem_write) break;
      n++;
      if (n > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rdwait_timeout: read never issued");
        break;
      end
    end
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("late_rdv_consumed", 32'(rd_due.size()), 0);
    check("late_rdv_no_write", 32'(wr_count - w0), 0);
    check_reset_vals("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
